ibex_instr_aligner: RTL and testbench

//  Sequencer between the 32-bit fetch stream and ibex_compressed_decoder.
//  - Splits word-aligned fetch words into 16/32-bit instructions, including 32-bit ones straddling two words.
//  - Tracks the instruction PC and hands each instruction, expanded by the decoder, to ID over valid/ready.
//  - Handles redirects (flush) to any half-word-aligned PC.

---
 rtl/ibex_aligner_pkg.sv | 25 ++
 rtl/ibex_compressed_decoder.sv | 115 +++++++++++
 rtl/ibex_instr_aligner.sv | 143 ++++++++++++++
 tb/tb_ibex_instr_aligner.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_aligner_pkg.sv
// Shared types and constants for the instruction aligner and its compressed decoder.
package ibex_aligner_pkg;

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    HALF    = 2'd1,
    SKIP    = 2'd2
  } aligner_state_e;

  localparam logic [1:0] HW_FULL = 2'b11;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;

  function automatic logic hw_is_compressed(input logic [15:0] hw);
    return hw[1:0] != HW_FULL;
  endfunction

endpackage

// File: rtl/ibex_compressed_decoder.sv
// RV32C expander: maps a 16-bit compressed instruction onto its 32-bit equivalent;
// full-width instructions pass through unchanged.
module ibex_compressed_decoder
  import ibex_aligner_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_instr,
  output logic        o_is_compressed,
  output logic        o_illegal_instr
);

  logic [15:0] w_c;
  logic [31:0] w_instr;
  logic        w_illegal;

  assign w_c = i_instr[15:0];

  always_comb begin
    w_instr   = i_instr;
    w_illegal = 1'b0;
    unique case (w_c[1:0])
      2'b00: begin
        case (w_c[15:13])
          3'b000: begin // c.addi4spn
            w_instr = {2'b00, w_c[10:7], w_c[12:11], w_c[5], w_c[6], 2'b00, 5'h02, 3'b000,
                       2'b01, w_c[4:2], OPC_OP_IMM};
            if (w_c[12:5] == 8'h00) w_illegal = 1'b1;
          end
          3'b010: w_instr = {5'b0, w_c[5], w_c[12:10], w_c[6], 2'b00, 2'b01, w_c[9:7], 3'b010,
                             2'b01, w_c[4:2], OPC_LOAD};
          3'b110: w_instr = {5'b0, w_c[5], w_c[12], 2'b01, w_c[4:2], 2'b01, w_c[9:7], 3'b010,
                             w_c[11:10], w_c[6], 2'b00, OPC_STORE};
          default: w_illegal = 1'b1;
        endcase
      end
      2'b01: begin
        case (w_c[15:13])
          3'b000: w_instr = {{6{w_c[12]}}, w_c[12], w_c[6:2], w_c[11:7], 3'b000, w_c[11:7], OPC_OP_IMM};
          3'b001, 3'b101: // c.jal / c.j; rd is x1 only for c.jal
            w_instr = {w_c[12], w_c[8], w_c[10:9], w_c[6], w_c[7], w_c[2], w_c[11], w_c[5:3],
                       {9{w_c[12]}}, 4'b0000, ~w_c[15], OPC_JAL};
          3'b010: w_instr = {{6{w_c[12]}}, w_c[12], w_c[6:2], 5'b0, 3'b000, w_c[11:7], OPC_OP_IMM};
          3'b011: begin
            if (w_c[11:7] == 5'h02) begin
              w_instr = {{3{w_c[12]}}, w_c[4:3], w_c[5], w_c[2], w_c[6], 4'b0000, 5'h02, 3'b000,
                         5'h02, OPC_OP_IMM};
            end else begin
              w_instr = {{15{w_c[12]}}, w_c[6:2], w_c[11:7], OPC_LUI};
            end
            if ({w_c[12], w_c[6:2]} == 6'h00) w_illegal = 1'b1;
          end
          3'b100: begin
            case (w_c[11:10])
              2'b00, 2'b01: begin
                w_instr = {1'b0, w_c[10], 5'b0, w_c[6:2], 2'b01, w_c[9:7], 3'b101, 2'b01, w_c[9:7],
                           OPC_OP_IMM};
                if (w_c[12]) w_illegal = 1'b1;
              end
              2'b10: w_instr = {{6{w_c[12]}}, w_c[12], w_c[6:2], 2'b01, w_c[9:7], 3'b111, 2'b01,
                                w_c[9:7], OPC_OP_IMM};
              default: begin
                case ({w_c[12], w_c[6:5]})
                  3'b000: w_instr = {2'b01, 5'b0, 2'b01, w_c[4:2], 2'b01, w_c[9:7], 3'b000, 2'b01, w_c[9:7], OPC_OP};
                  3'b001: w_instr = {7'b0, 2'b01, w_c[4:2], 2'b01, w_c[9:7], 3'b100, 2'b01, w_c[9:7], OPC_OP};
                  3'b010: w_instr = {7'b0, 2'b01, w_c[4:2], 2'b01, w_c[9:7], 3'b110, 2'b01, w_c[9:7], OPC_OP};
                  3'b011: w_instr = {7'b0, 2'b01, w_c[4:2], 2'b01, w_c[9:7], 3'b111, 2'b01, w_c[9:7], OPC_OP};
                  default: w_illegal = 1'b1;
                endcase
              end
            endcase
          end
          default: // c.beqz / c.bnez
            w_instr = {{4{w_c[12]}}, w_c[6:5], w_c[2], 5'b0, 2'b01, w_c[9:7], 2'b00, w_c[13],
                       w_c[11:10], w_c[4:3], w_c[12], OPC_BRANCH};
        endcase
      end
      2'b10: begin
        case (w_c[15:13])
          3'b000: begin
            w_instr = {7'b0, w_c[6:2], w_c[11:7], 3'b001, w_c[11:7], OPC_OP_IMM};
            if (w_c[12]) w_illegal = 1'b1;
          end
          3'b010: begin
            w_instr = {4'b0, w_c[3:2], w_c[12], w_c[6:4], 2'b00, 5'h02, 3'b010, w_c[11:7], OPC_LOAD};
            if (w_c[11:7] == 5'h00) w_illegal = 1'b1;
          end
          3'b100: begin
            if (!w_c[12]) begin
              if (w_c[6:2] != 5'h00) begin
                w_instr = {7'b0, w_c[6:2], 5'b0, 3'b000, w_c[11:7], OPC_OP};
              end else begin
                w_instr = {12'b0, w_c[11:7], 3'b000, 5'b0, OPC_JALR};
                if (w_c[11:7] == 5'h00) w_illegal = 1'b1;
              end
            end else if (w_c[6:2] != 5'h00) begin
              w_instr = {7'b0, w_c[6:2], w_c[11:7], 3'b000, w_c[11:7], OPC_OP};
            end else if (w_c[11:7] == 5'h00) begin
              w_instr = 32'h0010_0073;
            end else begin
              w_instr = {12'b0, w_c[11:7], 3'b000, 5'b00001, OPC_JALR};
            end
          end
          3'b110: w_instr = {4'b0, w_c[8:7], w_c[12], w_c[6:2], 5'h02, 3'b010, w_c[11:9], 2'b00, OPC_STORE};
          default: w_illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  assign o_instr         = w_instr;
  assign o_illegal_instr = w_illegal;
  assign o_is_compressed = w_c[1:0] != HW_FULL;

endmodule

// File: rtl/ibex_instr_aligner.sv
// Splits the 32-bit fetch stream into 16/32-bit instructions and tracks their PC.
// Optional IBEX_ALIGNER_PERF_EN adds accepted-instruction counters.
module ibex_instr_aligner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_raw_o,
  output logic        is_compressed_o,
  output logic        illegal_instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] cnt_comp_o,
  output logic [31:0] cnt_full_o
);
  import ibex_aligner_pkg::*;

  aligner_state_e r_st;
  logic [15:0]    r_hbuf;
  logic [31:0]    r_pc;

  logic        w_valid;
  logic        w_fetch_ready;
  logic [31:0] w_raw;
  logic        w_is_comp;
  logic        w_acc;
  logic [31:0] w_pc_inc;
  logic        w_unused_flush_pc0;
  logic        w_unused_dec_comp;

  assign w_unused_flush_pc0 = flush_pc_i[0];

  // A word is consumed only when the accepted instruction draws on its low half.
  always_comb begin
    w_valid       = 1'b0;
    w_fetch_ready = 1'b0;
    w_raw         = {16'h0000, fetch_rdata_i[15:0]};
    case (r_st)
      ALIGNED: begin
        if (!hw_is_compressed(fetch_rdata_i[15:0])) w_raw = fetch_rdata_i;
        w_valid       = fetch_valid_i;
        w_fetch_ready = fetch_valid_i & instr_ready_i;
      end
      HALF: begin
        if (hw_is_compressed(r_hbuf)) begin
          w_raw   = {16'h0000, r_hbuf};
          w_valid = 1'b1;
        end else begin
          w_raw         = {fetch_rdata_i[15:0], r_hbuf};
          w_valid       = fetch_valid_i;
          w_fetch_ready = fetch_valid_i & instr_ready_i;
        end
      end
      SKIP:    w_fetch_ready = fetch_valid_i;
      default: ;
    endcase
    if (flush_i) begin
      w_valid       = 1'b0;
      w_fetch_ready = 1'b0;
    end
  end

  assign w_is_comp = hw_is_compressed(w_raw[15:0]);
  assign w_acc     = w_valid & instr_ready_i;
  assign w_pc_inc  = {29'h0, ~w_is_comp, w_is_comp, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= ALIGNED;
      r_pc   <= BOOT_ADDR;
      r_hbuf <= '0;
    end else if (flush_i) begin
      r_st   <= flush_pc_i[1] ? SKIP : ALIGNED;
      r_pc   <= {flush_pc_i[31:1], 1'b0};
      r_hbuf <= '0;
    end else begin
      if (w_acc) r_pc <= r_pc + w_pc_inc;
      case (r_st)
        ALIGNED: begin
          if (w_acc && w_is_comp) begin
            r_hbuf <= fetch_rdata_i[31:16];
            r_st   <= HALF;
          end
        end
        HALF: begin
          if (w_acc) begin
            if (w_is_comp) r_st   <= ALIGNED;
            else           r_hbuf <= fetch_rdata_i[31:16];
          end
        end
        SKIP: begin
          if (fetch_valid_i) begin
            r_hbuf <= fetch_rdata_i[31:16];
            r_st   <= HALF;
          end
        end
        default: r_st <= ALIGNED;
      endcase
    end
  end

`ifdef IBEX_ALIGNER_PERF_EN
  logic [31:0] r_cnt_comp;
  logic [31:0] r_cnt_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_comp <= '0;
      r_cnt_full <= '0;
    end else if (w_acc) begin
      if (w_is_comp) r_cnt_comp <= r_cnt_comp + 32'd1;
      else           r_cnt_full <= r_cnt_full + 32'd1;
    end
  end

  assign cnt_comp_o = r_cnt_comp;
  assign cnt_full_o = r_cnt_full;
`else
  assign cnt_comp_o = '0;
  assign cnt_full_o = '0;
`endif

  ibex_compressed_decoder u_dec (
    .i_instr         (w_raw),
    .o_instr         (instr_o),
    .o_is_compressed (w_unused_dec_comp),
    .o_illegal_instr (illegal_instr_o)
  );

  assign instr_valid_o   = w_valid;
  assign fetch_ready_o   = w_fetch_ready;
  assign instr_raw_o     = w_raw;
  assign is_compressed_o = w_is_comp;
  assign pc_o            = r_pc;

endmodule

// File: tb/tb_ibex_instr_aligner.sv
// Self-checking bench: half-word queue reference model plus directed literal scenarios.
module tb_ibex_instr_aligner;

  localparam logic [31:0] BOOT = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_raw_o;
  logic        is_compressed_o;
  logic        illegal_instr_o;
  logic [31:0] pc_o;
  logic [31:0] cnt_comp_o;
  logic [31:0] cnt_full_o;

  ibex_instr_aligner #(.BOOT_ADDR(BOOT)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_ready_o   (fetch_ready_o),
    .fetch_rdata_i   (fetch_rdata_i),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .instr_raw_o     (instr_raw_o),
    .is_compressed_o (is_compressed_o),
    .illegal_instr_o (illegal_instr_o),
    .pc_o            (pc_o),
    .cnt_comp_o      (cnt_comp_o),
    .cnt_full_o      (cnt_full_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-expanded compressed encodings: c.li a0,0 / c.li a0,1 / c.nop / c.mv a0,a1 / c.lw a0,0(a1) / c.slli a0,1
  logic [15:0] tbl_hw [6] = '{16'h4501, 16'h4505, 16'h0001, 16'h852E, 16'h4188, 16'h0506};
  logic [31:0] tbl_ex [6] = '{32'h0000_0513, 32'h0010_0513, 32'h0000_0013, 32'h00B0_0533,
                              32'h0005_A503, 32'h0015_1513};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: pending half-words plus a skip flag for odd-half redirects.
  logic [15:0] mq[$];
  logic [15:0] avail[$];
  bit          m_skip = 1'b0;
  logic [31:0] m_pc = BOOT;
  logic [31:0] m_cc = '0;
  logic [31:0] m_cf = '0;
  bit          e_valid, e_fr, e_useword;
  int          e_len;
  logic [31:0] e_raw;

  function automatic void model_eval();
    avail = mq;
    e_valid = 1'b0; e_fr = 1'b0; e_useword = 1'b0; e_len = 0; e_raw = '0;
    if (!m_skip && fetch_valid_i) begin
      avail.push_back(fetch_rdata_i[15:0]);
      avail.push_back(fetch_rdata_i[31:16]);
    end
    if (flush_i) return;
    if (m_skip) begin
      e_fr = fetch_valid_i;
      return;
    end
    if (avail.size() > 0) begin
      if (avail[0][1:0] != 2'b11) begin
        e_len = 1; e_raw = {16'h0000, avail[0]};
      end else if (avail.size() >= 2) begin
        e_len = 2; e_raw = {avail[1], avail[0]};
      end
    end
    e_valid   = (e_len != 0);
    e_useword = e_valid && (e_len > mq.size());
    e_fr      = e_useword && instr_ready_i;
  endfunction

  function automatic void model_advance();
    if (rst) begin
      mq.delete(); m_skip = 1'b0; m_pc = BOOT; m_cc = '0; m_cf = '0;
      return;
    end
    if (flush_i) begin
      mq.delete(); m_skip = flush_pc_i[1]; m_pc = {flush_pc_i[31:1], 1'b0};
      return;
    end
    if (m_skip) begin
      if (fetch_valid_i) begin
        mq.delete(); mq.push_back(fetch_rdata_i[31:16]); m_skip = 1'b0;
      end
      return;
    end
    if (e_valid && instr_ready_i) begin
      m_pc = m_pc + 32'(2 * e_len);
      if (e_len == 1) m_cc = m_cc + 1;
      else            m_cf = m_cf + 1;
      if (e_useword) mq = avail;
      repeat (e_len) void'(mq.pop_front());
    end
  endfunction

  task automatic check_model();
    chk("valid", 32'(instr_valid_o), 32'(e_valid));
    chk("fetch_ready", 32'(fetch_ready_o), 32'(e_fr));
    if (e_valid) begin
      chk("raw", instr_raw_o, e_raw);
      chk("pc", pc_o, m_pc);
      chk("is_comp", 32'(is_compressed_o), 32'(e_len == 1));
      if (e_len == 2) chk("instr_full", instr_o, e_raw);
      for (int i = 0; i < 6; i++) begin
        if (e_len == 1 && e_raw[15:0] == tbl_hw[i]) begin
          chk("instr_exp", instr_o, tbl_ex[i]);
          chk("legal", 32'(illegal_instr_o), 32'h0);
        end
      end
    end
`ifdef IBEX_ALIGNER_PERF_EN
    chk("cnt_comp", cnt_comp_o, m_cc);
    chk("cnt_full", cnt_full_o, m_cf);
`else
    chk("cnt_comp", cnt_comp_o, 32'h0);
    chk("cnt_full", cnt_full_o, 32'h0);
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    model_eval();
    if (!rst) check_model();
  endtask

  task automatic adv();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit fv, input logic [31:0] w, input bit ir,
                       input bit fl, input logic [31:0] fpc);
    rst = 1'b0; fetch_valid_i = fv; fetch_rdata_i = w; instr_ready_i = ir;
    flush_i = fl; flush_pc_i = fpc;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_valid_i = 1'b0; flush_i = 1'b0; instr_ready_i = 1'b0;
    tick(); adv();
    tick(); adv();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_hw();
    int k;
    logic [15:0] h;
    k = $urandom_range(0, 9);
    h = 16'($urandom());
    if (k < 3) return tbl_hw[$urandom_range(0, 5)];
    if (k < 6) h[1:0] = 2'b11;
    return h;
  endfunction

  function automatic logic [31:0] pick_pc();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 | (32'($urandom_range(0, 15)) & 32'hFFFF_FFFE);
    return $urandom() & 32'hFFFF_FFFE;
  endfunction

  initial begin
    // Reset state
    do_reset();
    drive(0, '0, 0, 0, '0);
    tick();
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
    chk("rst_fready", 32'(fetch_ready_o), 32'h0);
    chk("rst_pc", pc_o, 32'h80);
    chk("rst_cnt", cnt_comp_o | cnt_full_o, 32'h0);
    adv();

    // Full instruction, zero latency
    drive(1, 32'h0000_0013, 1, 0, '0);
    tick();
    chk("s1_valid", 32'(instr_valid_o), 32'h1);
    chk("s1_raw", instr_raw_o, 32'h13);
    chk("s1_comp", 32'(is_compressed_o), 32'h0);
    chk("s1_pc", pc_o, 32'h80);
    chk("s1_fready", 32'(fetch_ready_o), 32'h1);
    adv();

    // Two compressed in one word
    do_reset();
    drive(1, 32'h4505_4501, 1, 0, '0);
    tick();
    chk("s2_raw0", instr_raw_o, 32'h4501);
    chk("s2_instr0", instr_o, 32'h0000_0513);
    chk("s2_pc0", pc_o, 32'h80);
    adv();
    drive(0, 32'h4505_4501, 1, 0, '0);
    tick();
    chk("s2_raw1", instr_raw_o, 32'h4505);
    chk("s2_instr1", instr_o, 32'h0010_0513);
    chk("s2_pc1", pc_o, 32'h82);
    chk("s2_fready1", 32'(fetch_ready_o), 32'h0);
    adv();

    // Straddling 32-bit instruction
    do_reset();
    drive(1, 32'h0013_4501, 1, 0, '0);
    tick();
    chk("s3_raw0", instr_raw_o, 32'h4501);
    chk("s3_pc0", pc_o, 32'h80);
    adv();
    drive(1, 32'h1234_0000, 1, 0, '0);
    tick();
    chk("s3_raw1", instr_raw_o, 32'h0000_0013);
    chk("s3_pc1", pc_o, 32'h82);
    chk("s3_fready1", 32'(fetch_ready_o), 32'h1);
    adv();
    drive(0, '0, 1, 0, '0);
    tick();
    chk("s3_raw2", instr_raw_o, 32'h1234);
    chk("s3_pc2", pc_o, 32'h86);
    chk("s3_comp2", 32'(is_compressed_o), 32'h1);
    adv();
    drive(0, '0, 1, 0, '0);
    tick();
`ifdef IBEX_ALIGNER_PERF_EN
    chk("s6_cnt_comp", cnt_comp_o, 32'd2);
    chk("s6_cnt_full", cnt_full_o, 32'd1);
`else
    chk("s6_cnt_comp", cnt_comp_o, 32'd0);
    chk("s6_cnt_full", cnt_full_o, 32'd0);
`endif
    adv();

    // Flush to odd half-word
    do_reset();
    drive(0, '0, 1, 1, 32'h0000_0102);
    tick();
    chk("s4_flush_valid", 32'(instr_valid_o), 32'h0);
    adv();
    drive(1, 32'h0001_FFFF, 1, 0, '0);
    tick();
    chk("s4_skip_valid", 32'(instr_valid_o), 32'h0);
    chk("s4_skip_fready", 32'(fetch_ready_o), 32'h1);
    adv();
    drive(0, '0, 1, 0, '0);
    tick();
    chk("s4_raw", instr_raw_o, 32'h0001);
    chk("s4_instr", instr_o, 32'h0000_0013);
    chk("s4_pc", pc_o, 32'h102);
    adv();

    // Backpressure, then flush discards the held instruction
    do_reset();
    drive(1, 32'h4505_4501, 1, 0, '0);
    tick(); adv();
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 0, 0, '0);
      tick();
      chk("s5_hold_valid", 32'(instr_valid_o), 32'h1);
      chk("s5_hold_raw", instr_raw_o, 32'h4505);
      chk("s5_hold_pc", pc_o, 32'h82);
      adv();
    end
    drive(0, '0, 1, 1, 32'h0000_0200);
    tick();
    chk("s5_flush_valid", 32'(instr_valid_o), 32'h0);
    adv();
    drive(1, 32'h0000_0013, 1, 0, '0);
    tick();
    chk("s5_pc", pc_o, 32'h200);
    chk("s5_raw", instr_raw_o, 32'h13);
    adv();

    // PC wrap across 2^32
    do_reset();
    drive(0, '0, 1, 1, 32'hFFFF_FFFE);
    tick(); adv();
    drive(1, 32'h0001_0000, 1, 0, '0);
    tick(); adv();
    drive(0, '0, 1, 0, '0);
    tick();
    chk("wrap_pc0", pc_o, 32'hFFFF_FFFE);
    adv();
    drive(1, 32'h0000_0013, 1, 0, '0);
    tick();
    chk("wrap_pc1", pc_o, 32'h0000_0000);
    adv();

    // Decoder: illegal zero encoding, c.lw expansion
    do_reset();
    drive(1, 32'h0000_0000, 1, 0, '0);
    tick();
    chk("illegal_zero", 32'(illegal_instr_o), 32'h1);
    chk("illegal_comp", 32'(is_compressed_o), 32'h1);
    adv();
    drive(0, '0, 1, 0, '0);
    tick(); adv();
    drive(1, 32'h0001_4188, 1, 0, '0);
    tick();
    chk("c_lw", instr_o, 32'h0005_A503);
    adv();

    // Randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      bit hold;
      hold = fetch_valid_i && !e_fr && !flush_i && !rst;
      rst = ($urandom_range(0, 499) == 0);
      flush_i = ($urandom_range(0, 15) == 0);
      if (flush_i) flush_pc_i = pick_pc();
      instr_ready_i = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        fetch_valid_i = ($urandom_range(0, 3) != 0);
        fetch_rdata_i = {rand_hw(), rand_hw()};
      end
      tick(); adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
